sample_packer: RTL

Packs the 2-bit quantized sample stream from the quantizer into 32-bit words, 16 samples per word. Completed words are buffered in a small FIFO and offered downstream on a valid/ready interface to the packet/framing logic. An `align` strobe restarts word packing at a known sample boundary. Lost words are reported through a sticky overflow flag and a saturating drop counter.

---
 rtl/sample_packer.sv | 101 ++++++++++
 1 files changed

// File: rtl/sample_packer.sv
// Packs 2-bit quantizer samples into 32-bit words (slot 0 in the MSBs) and
// queues completed words in a small FIFO with a valid/ready output port.
module sample_packer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_y,
  input  logic        align,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [15:0] drop_count,
  input  logic        clear_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    slot;
  logic [31:0]   partial;
  logic [31:0]   assembled;
  logic [4:0]    shamt;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [31:0]   mem [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          drop;

  // The incoming sample is merged into the partial word at its slot position.
  always_comb begin
    shamt     = {slot, 1'b0};
    assembled = partial | ({in_y, 30'b0} >> shamt);
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = in_valid && !align && (slot == 4'd15);
  assign pop     = out_valid && out_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign out_valid = !empty;
  assign out_data  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

  // Align discards the partial word without counting it as a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot    <= 4'd0;
      partial <= 32'h0;
    end else if (align) begin
      slot    <= in_valid ? 4'd1 : 4'd0;
      partial <= in_valid ? {in_y, 30'b0} : 32'h0;
    end else if (in_valid) begin
      if (slot == 4'd15) begin
        slot    <= 4'd0;
        partial <= 32'h0;
      end else begin
        slot    <= slot + 4'd1;
        partial <= assembled;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= assembled;
  end

  // A drop on the same edge as clear_ovf wins and restarts the count at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= 16'h0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clear_ovf)
        drop_count <= 16'h1;
      else if (drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= 16'h0;
    end
  end

endmodule
